cache_fill_sequencer: RTL and testbench

- Sits directly downstream of the two-way instruction/data cache, between the cache's SDRAM-side request port and the word-wide memory port of the SDRAM controller.
- Converts a cache line-fill request into BURST_LEN single-word memory reads and buffers the returned words.
- Replays the buffered words to the cache as one gap-free burst: fill strobe on the first word, then the remaining words on consecutive cycles.
- Also forwards single-word cache writes to memory with a write acknowledge.

---
 rtl/cache_fill_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_cache_fill_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_sequencer.sv
// Cache fill sequencer: turns a cache line fill into BURST_LEN word reads,
// buffers them and replays them as one gap-free burst; forwards single writes.
//
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   cache_addr/req/rw     : cache request (rw=1 line fill, rw=0 word write)
//   cache_wdata           : cache write data
//   cache_rdata/fill      : burst data to cache, fill marks word 0
//   cache_wack            : one-cycle write-complete strobe
//   busy                  : high whenever the sequencer is not idle
//   mem_addr/req/wr/wdata : word-wide memory request port
//   mem_ack/rdata         : memory completion and read data
module cache_fill_sequencer #(
   parameter int BURST_LEN = 4,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cache_addr,
   input  logic              cache_req,
   input  logic              cache_rw,
   input  logic [15:0]       cache_wdata,
   output logic [15:0]       cache_rdata,
   output logic              cache_fill,
   output logic              cache_wack,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata
);

   localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int LW = CW + 1;
   localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
   localparam logic [ADDR_W-1:0] BASE_MASK = ~(ADDR_W'(2 * BURST_LEN - 1));
   localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(1));

   typedef enum logic [2:0] {
      IDLE,
      RD_MEM,
      STREAM,
      WR_MEM,
      HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_wr_q, mem_wr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic [15:0]       cache_rdata_q, cache_rdata_d;
   logic              cache_fill_q, cache_fill_d;
   logic              cache_wack_q, cache_wack_d;
   logic              busy_q, busy_d;
   logic [15:0]       buf_q [BURST_LEN];
   logic [15:0]       buf_d [BURST_LEN];

   logic [LW-1:0]     off_inc;
   logic [ADDR_W-1:0] addr_next;
   logic              ack_ok;

   // Increment stays inside the line: the aligned base never carries out.
   assign off_inc   = mem_addr_q[LW-1:0] + LW'(2);
   assign addr_next = {mem_addr_q[ADDR_W-1:LW], off_inc};
   assign ack_ok    = mem_ack && mem_req_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mem_addr_d    = mem_addr_q;
      mem_req_d     = mem_req_q;
      mem_wr_d      = mem_wr_q;
      mem_wdata_d   = mem_wdata_q;
      cache_rdata_d = cache_rdata_q;
      cache_fill_d  = 1'b0;
      cache_wack_d  = 1'b0;
      buf_d         = buf_q;

      unique case (state_q)
         IDLE: begin
            if (cache_req) begin
               mem_req_d = 1'b1;
               if (cache_rw) begin
                  mem_addr_d = cache_addr & BASE_MASK;
                  mem_wr_d   = 1'b0;
                  cnt_d      = '0;
                  state_d    = RD_MEM;
               end else begin
                  mem_addr_d  = cache_addr & WORD_MASK;
                  mem_wdata_d = cache_wdata;
                  mem_wr_d    = 1'b1;
                  state_d     = WR_MEM;
               end
            end
         end
         RD_MEM: begin
            if (ack_ok) begin
               buf_d[cnt_q] = mem_rdata;
               mem_addr_d   = addr_next;
               cnt_d        = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  // Word 0 leaves on the same edge as the last ack,
                  // so the counter then points at the next word.
                  mem_req_d     = 1'b0;
                  cache_rdata_d = buf_q[0];
                  cache_fill_d  = 1'b1;
                  cnt_d         = CW'(1);
                  state_d       = STREAM;
               end
            end
         end
         STREAM: begin
            cache_rdata_d = buf_q[cnt_q];
            cnt_d         = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = HOLD;
            end
         end
         WR_MEM: begin
            if (ack_ok) begin
               mem_req_d    = 1'b0;
               mem_wr_d     = 1'b0;
               cache_wack_d = 1'b1;
               state_d      = HOLD;
            end
         end
         HOLD: begin
            if (!cache_req) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         mem_addr_q    <= '0;
         mem_req_q     <= 1'b0;
         mem_wr_q      <= 1'b0;
         mem_wdata_q   <= '0;
         cache_rdata_q <= '0;
         cache_fill_q  <= 1'b0;
         cache_wack_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mem_addr_q    <= mem_addr_d;
         mem_req_q     <= mem_req_d;
         mem_wr_q      <= mem_wr_d;
         mem_wdata_q   <= mem_wdata_d;
         cache_rdata_q <= cache_rdata_d;
         cache_fill_q  <= cache_fill_d;
         cache_wack_q  <= cache_wack_d;
         busy_q        <= busy_d;
      end
   end

   // Line buffer contents are don't-care after reset.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign cache_rdata = cache_rdata_q;
   assign cache_fill  = cache_fill_q;
   assign cache_wack  = cache_wack_q;
   assign busy        = busy_q;
   assign mem_addr    = mem_addr_q;
   assign mem_req     = mem_req_q;
   assign mem_wr      = mem_wr_q;
   assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_cache_fill_sequencer.sv
// Self-checking bench for cache_fill_sequencer: directed and random fills
// and writes against a transaction-level model of the memory and cache.
module tb_cache_fill_sequencer;

   localparam int B  = 4;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] cache_addr;
   logic          cache_req;
   logic          cache_rw;
   logic [15:0]   cache_wdata;
   logic [15:0]   cache_rdata;
   logic          cache_fill;
   logic          cache_wack;
   logic          busy;
   logic [AW-1:0] mem_addr;
   logic          mem_req;
   logic          mem_wr;
   logic [15:0]   mem_wdata;
   logic          mem_ack;
   logic [15:0]   mem_rdata;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            waits [B];
   logic [15:0]   wdat [B];
   logic [AW-1:0] obs_addr [B];

   cache_fill_sequencer #(.BURST_LEN(B), .ADDR_W(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .cache_addr  (cache_addr),
      .cache_req   (cache_req),
      .cache_rw    (cache_rw),
      .cache_wdata (cache_wdata),
      .cache_rdata (cache_rdata),
      .cache_fill  (cache_fill),
      .cache_wack  (cache_wack),
      .busy        (busy),
      .mem_addr    (mem_addr),
      .mem_req     (mem_req),
      .mem_wr      (mem_wr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " rdata"}, 32'(cache_rdata), 0);
      chk({tag, " fill"},  32'(cache_fill), 0);
      chk({tag, " wack"},  32'(cache_wack), 0);
      chk({tag, " busy"},  32'(busy), 0);
      chk({tag, " maddr"}, mem_addr, 0);
      chk({tag, " mreq"},  32'(mem_req), 0);
      chk({tag, " mwr"},   32'(mem_wr), 0);
      chk({tag, " mwd"},   32'(mem_wdata), 0);
   endtask

   // Non-request inputs are scrambled while busy; they must be ignored.
   task automatic scramble();
      cache_addr  = $urandom;
      cache_rw    = 1'($urandom);
      cache_wdata = 16'($urandom);
   endtask

   task automatic do_fill(input logic [AW-1:0] addr, input int hold,
                          input bit directed);
      logic [AW-1:0] base;
      base = addr & ~(AW'(2 * B - 1));
      for (int i = 0; i < B; i++)
         wdat[i] = directed ? 16'hA000 + 16'(i) : 16'($urandom);
      cache_req   = 1'b1;
      cache_rw    = 1'b1;
      cache_addr  = addr;
      cache_wdata = 16'($urandom);
      step();
      for (int i = 0; i < B; i++) begin
         for (int w = 0; w <= waits[i]; w++) begin
            scramble();
            chk("rd mreq", 32'(mem_req), 1);
            chk("rd mwr", 32'(mem_wr), 0);
            chk("rd maddr", mem_addr, base + AW'(2 * i));
            chk("rd fill", 32'(cache_fill), 0);
            chk("rd busy", 32'(busy), 1);
            obs_addr[i] = mem_addr;
            if (w == waits[i]) begin
               mem_ack   = 1'b1;
               mem_rdata = wdat[i];
            end
            step();
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
         end
      end
      for (int k = 0; k < B; k++) begin
         chk("st fill", 32'(cache_fill), (k == 0) ? 1 : 0);
         chk("st data", 32'(cache_rdata), 32'(wdat[k]));
         chk("st mreq", 32'(mem_req), 0);
         chk("st busy", 32'(busy), 1);
         step();
      end
      for (int h = 0; h <= hold; h++) begin
         chk("hd fill", 32'(cache_fill), 0);
         chk("hd data", 32'(cache_rdata), 32'(wdat[B-1]));
         chk("hd mreq", 32'(mem_req), 0);
         chk("hd busy", 32'(busy), 1);
         if (h < hold) step();
      end
      cache_req = 1'b0;
      step();
      chk("fill end busy", 32'(busy), 0);
      chk("fill end mreq", 32'(mem_req), 0);
      chk("fill end data", 32'(cache_rdata), 32'(wdat[B-1]));
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [15:0] data,
                           input int wt, input int hold);
      cache_req   = 1'b1;
      cache_rw    = 1'b0;
      cache_addr  = addr;
      cache_wdata = data;
      step();
      for (int w = 0; w <= wt; w++) begin
         scramble();
         chk("wr mreq", 32'(mem_req), 1);
         chk("wr mwr", 32'(mem_wr), 1);
         chk("wr maddr", mem_addr, addr & ~(AW'(1)));
         chk("wr mwd", 32'(mem_wdata), 32'(data));
         chk("wr wack", 32'(cache_wack), 0);
         chk("wr busy", 32'(busy), 1);
         if (w == wt) mem_ack = 1'b1;
         step();
         mem_ack = 1'b0;
      end
      chk("wack pulse", 32'(cache_wack), 1);
      chk("wack mreq", 32'(mem_req), 0);
      chk("wack mwr", 32'(mem_wr), 0);
      for (int h = 0; h < hold; h++) begin
         step();
         chk("wh wack", 32'(cache_wack), 0);
         chk("wh mreq", 32'(mem_req), 0);
         chk("wh busy", 32'(busy), 1);
      end
      cache_req = 1'b0;
      step();
      chk("wr end busy", 32'(busy), 0);
      chk("wr end wack", 32'(cache_wack), 0);
      chk("wr end mreq", 32'(mem_req), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset       = 1'b1;
      cache_addr  = '0;
      cache_req   = 1'b0;
      cache_rw    = 1'b0;
      cache_wdata = '0;
      mem_ack     = 1'b0;
      mem_rdata   = '0;
      step();
      step();
      chk_zero("reset");
      reset = 1'b0;
      step();

      // Zero-wait line fill, addresses pinned by literals.
      for (int i = 0; i < B; i++) waits[i] = 0;
      do_fill(32'h0000_1236, 1, 1'b1);
      chk("lit a0", obs_addr[0], 32'h0000_1230);
      chk("lit a1", obs_addr[1], 32'h0000_1232);
      chk("lit a2", obs_addr[2], 32'h0000_1234);
      chk("lit a3", obs_addr[3], 32'h0000_1236);

      // Wait states 0,3,1,5.
      waits[0] = 0; waits[1] = 3; waits[2] = 1; waits[3] = 5;
      do_fill(32'h0000_1236, 0, 1'b1);

      // Single write with request held 4 extra cycles.
      do_write(32'h0040_0011, 16'hBEEF, 2, 4);

      // Reset after two acks of a fill; stray acks afterwards.
      cache_req  = 1'b1;
      cache_rw   = 1'b1;
      cache_addr = 32'h0000_2000;
      step();
      mem_ack = 1'b1;
      step();
      step();
      reset     = 1'b1;
      cache_req = 1'b0;
      step();
      chk_zero("midrst");
      reset = 1'b0;
      step();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stray fill", 32'(cache_fill), 0);
         chk("stray busy", 32'(busy), 0);
         chk("stray mreq", 32'(mem_req), 0);
         step();
      end
      for (int i = 0; i < B; i++) waits[i] = 0;
      do_fill(32'h0000_0008, 0, 1'b1);

      // Top of the address space.
      do_fill(32'hFFFF_FFFE, 0, 1'b0);
      chk("top a0", obs_addr[0], 32'hFFFF_FFF8);
      chk("top a1", obs_addr[1], 32'hFFFF_FFFA);
      chk("top a2", obs_addr[2], 32'hFFFF_FFFC);
      chk("top a3", obs_addr[3], 32'hFFFF_FFFE);

      // Random mix of fills, writes and idle stray acks.
      for (int t = 0; t < 40; t++) begin
         int idle;
         idle = $urandom_range(0, 2);
         for (int i = 0; i < idle; i++) begin
            mem_ack = 1'($urandom);
            step();
            mem_ack = 1'b0;
            chk("idle fill", 32'(cache_fill), 0);
            chk("idle wack", 32'(cache_wack), 0);
            chk("idle busy", 32'(busy), 0);
            chk("idle mreq", 32'(mem_req), 0);
         end
         for (int i = 0; i < B; i++) waits[i] = $urandom_range(0, 3);
         if ($urandom_range(0, 2) != 0)
            do_fill($urandom, $urandom_range(0, 3), 1'b0);
         else
            do_write($urandom, 16'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
